// File: rtl/z_core_exec_ctrl.sv
// Execute sequencer for RV32I integer ops: decodes a latched instruction, drives
// an external ALU for one cycle (two for branches) and holds the result until taken.
module z_core_exec_ctrl #(
  parameter bit CHECK_FUNCT7 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_inst_type,
  input  logic [31:0] alu_out,
  input  logic        alu_branch,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] next_pc,
  output logic        unsup
);
  localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_SLL = 4'd2, T_SLT = 4'd3,
                         T_SLTU = 4'd4, T_XOR = 4'd5, T_SRL = 4'd6, T_SRA = 4'd7,
                         T_OR = 4'd8, T_AND = 4'd9;
  localparam logic [6:0] OPC_OP = 7'h33, OPC_IMM = 7'h13, OPC_LUI = 7'h37,
                         OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67,
                         OPC_BR = 7'h63;

  typedef enum logic [1:0] {IDLE, EXEC, BR_TGT, DONE} state_e;

  state_e      state_q;
  logic [31:0] instr_q, pc_q, rs1_q, rs2_q;
  logic        taken_q;
  logic        res_valid_q, rd_we_q, unsup_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data_q, next_pc_q;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_u, imm_j, imm_b, pc_inc;
  logic [3:0]  dec_type;
  logic [31:0] dec_in1, dec_in2;
  logic        dec_unsup, dec_wr, dec_br, dec_link, f7_ok;

  assign opc    = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_b  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign pc_inc = pc_q + 32'd4;
  assign f7_ok  = !CHECK_FUNCT7 || (f7 == 7'h00) || (f7 == 7'h20);

  function automatic logic [3:0] f3_type(input logic [2:0] fn, input logic alt);
    case (fn)
      3'd0:    f3_type = alt ? T_SUB : T_ADD;
      3'd1:    f3_type = T_SLL;
      3'd2:    f3_type = T_SLT;
      3'd3:    f3_type = T_SLTU;
      3'd4:    f3_type = T_XOR;
      3'd5:    f3_type = alt ? T_SRA : T_SRL;
      3'd6:    f3_type = T_OR;
      default: f3_type = T_AND;
    endcase
  endfunction

  always_comb begin
    dec_type  = T_ADD;
    dec_in1   = '0;
    dec_in2   = '0;
    dec_unsup = 1'b0;
    dec_wr    = 1'b0;
    dec_br    = 1'b0;
    dec_link  = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_in1   = rs1_q;
        dec_in2   = rs2_q;
        dec_wr    = 1'b1;
        dec_type  = f3_type(f3, f7[5]);
        dec_unsup = !f7_ok || (f7[5] && f3 != 3'd0 && f3 != 3'd5);
      end
      OPC_IMM: begin
        dec_in1 = rs1_q;
        dec_wr  = 1'b1;
        // funct7 only exists for the shift forms; elsewhere those bits are immediate
        if (f3 == 3'd1 || f3 == 3'd5) begin
          dec_in2   = {27'b0, instr_q[24:20]};
          dec_type  = f3_type(f3, f7[5]);
          dec_unsup = !f7_ok || (f7[5] && f3 == 3'd1);
        end else begin
          dec_in2  = imm_i;
          dec_type = f3_type(f3, 1'b0);
        end
      end
      OPC_LUI:   begin dec_in2 = imm_u; dec_wr = 1'b1; end
      OPC_AUIPC: begin dec_in1 = pc_q; dec_in2 = imm_u; dec_wr = 1'b1; end
      OPC_JAL:   begin dec_in1 = pc_q; dec_in2 = imm_j; dec_wr = 1'b1; dec_link = 1'b1; end
      OPC_JALR:  begin dec_in1 = rs1_q; dec_in2 = imm_i; dec_wr = 1'b1; dec_link = 1'b1; end
      OPC_BR: begin
        dec_in1 = rs1_q;
        dec_in2 = rs2_q;
        dec_br  = 1'b1;
        case (f3)
          3'd0: dec_type = 4'd10;
          3'd1: dec_type = 4'd11;
          3'd4: dec_type = 4'd12;
          3'd5: dec_type = 4'd13;
          3'd6: dec_type = 4'd14;
          3'd7: dec_type = 4'd15;
          default: dec_unsup = 1'b1;
        endcase
      end
      default: dec_unsup = 1'b1;
    endcase
  end

  always_comb begin
    alu_inst_type = T_ADD;
    alu_in1       = '0;
    alu_in2       = '0;
    if (state_q == EXEC && !dec_unsup) begin
      alu_inst_type = dec_type;
      alu_in1       = dec_in1;
      alu_in2       = dec_in2;
    end else if (state_q == BR_TGT) begin
      alu_in1 = pc_q;
      alu_in2 = taken_q ? imm_b : 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      taken_q     <= 1'b0;
      res_valid_q <= 1'b0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      next_pc_q   <= '0;
      unsup_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (instr_valid) begin
          instr_q <= instr;
          pc_q    <= pc;
          rs1_q   <= rs1_data;
          rs2_q   <= rs2_data;
          state_q <= EXEC;
        end
        EXEC: begin
          unsup_q   <= dec_unsup;
          rd_we_q   <= dec_wr && !dec_unsup && (rd != 5'd0);
          rd_addr_q <= (dec_wr && !dec_unsup) ? rd : 5'd0;
          if (dec_unsup) begin
            rd_data_q   <= '0;
            next_pc_q   <= pc_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (dec_br) begin
            taken_q   <= alu_branch;
            rd_data_q <= '0;
            state_q   <= BR_TGT;
          end else begin
            if (dec_link) begin
              rd_data_q <= pc_inc;
              next_pc_q <= alu_out & ~{31'b0, opc == OPC_JALR};
            end else begin
              rd_data_q <= alu_out;
              next_pc_q <= pc_inc;
            end
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        BR_TGT: begin
          next_pc_q   <= alu_out;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        default: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE) && !rst;
  assign res_valid   = res_valid_q;
  assign rd_we       = rd_we_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign next_pc     = next_pc_q;
  assign unsup       = unsup_q;
endmodule

// File: tb/tb_z_core_exec_ctrl.sv
// Bench for z_core_exec_ctrl: behavioural ALU on the driven side, RV32I-semantics
// reference model for expected writeback/next-PC, directed steps plus random mix.
module tb_z_core_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0, instr_ready;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_inst_type;
  logic        alu_branch;
  logic        res_valid, res_ready = 1'b0, rd_we, unsup;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, next_pc;

  int n_cmp = 0, n_bad = 0;
  logic        o_we, o_uns;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_npc;
  int          o_lat;

  z_core_exec_ctrl #(.CHECK_FUNCT7(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_inst_type(alu_inst_type),
    .alu_out(alu_out), .alu_branch(alu_branch), .res_valid(res_valid),
    .res_ready(res_ready), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .next_pc(next_pc), .unsup(unsup));

  always #5 clk = ~clk;

  // External ALU; branch codes return junk on alu_out so any misuse shows up
  always_comb begin
    alu_out    = 32'hDEADBEEF;
    alu_branch = 1'b0;
    case (alu_inst_type)
      4'd0:  alu_out = alu_in1 + alu_in2;
      4'd1:  alu_out = alu_in1 - alu_in2;
      4'd2:  alu_out = alu_in1 << alu_in2[4:0];
      4'd3:  alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      4'd4:  alu_out = {31'b0, alu_in1 < alu_in2};
      4'd5:  alu_out = alu_in1 ^ alu_in2;
      4'd6:  alu_out = alu_in1 >> alu_in2[4:0];
      4'd7:  alu_out = $signed(alu_in1) >>> alu_in2[4:0];
      4'd8:  alu_out = alu_in1 | alu_in2;
      4'd9:  alu_out = alu_in1 & alu_in2;
      4'd10: alu_branch = alu_in1 == alu_in2;
      4'd11: alu_branch = alu_in1 != alu_in2;
      4'd12: alu_branch = $signed(alu_in1) < $signed(alu_in2);
      4'd13: alu_branch = $signed(alu_in1) >= $signed(alu_in2);
      4'd14: alu_branch = alu_in1 < alu_in2;
      default: alu_branch = alu_in1 >= alu_in2;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2, r1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  // Architectural result of one instruction
  task automatic ref_model(input logic [31:0] in, ipc, a, b, output logic u, we, br,
                           output logic [4:0] rd, output logic [31:0] data, npc);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] ii, iu, ij, ib, s2;
    logic [4:0]  sh;
    logic        wr, t;
    op = in[6:0]; f3 = in[14:12]; f7 = in[31:25]; rd = in[11:7];
    ii = {{20{in[31]}}, in[31:20]};
    iu = {in[31:12], 12'b0};
    ij = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
    ib = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
    u = 0; wr = 0; br = 0; data = 0; npc = ipc + 4; t = 0;
    case (op)
      7'h33, 7'h13: begin
        s2 = (op == 7'h33) ? b : ii;
        sh = (op == 7'h33) ? b[4:0] : in[24:20];
        wr = 1;
        if (op == 7'h33 || f3 == 3'd1 || f3 == 3'd5)
          u = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd5 || (f3 == 3'd0 && op == 7'h33))));
        case (f3)
          3'd0: data = (op == 7'h33 && f7[5]) ? a - s2 : a + s2;
          3'd1: data = a << sh;
          3'd2: data = ($signed(a) < $signed(s2)) ? 32'd1 : 32'd0;
          3'd3: data = (a < s2) ? 32'd1 : 32'd0;
          3'd4: data = a ^ s2;
          3'd5: data = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: data = a | s2;
          default: data = a & s2;
        endcase
      end
      7'h37: begin wr = 1; data = iu; end
      7'h17: begin wr = 1; data = ipc + iu; end
      7'h6f: begin wr = 1; data = ipc + 4; npc = ipc + ij; end
      7'h67: begin wr = 1; data = ipc + 4; npc = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        br = 1;
        case (f3)
          3'd0: t = a == b;
          3'd1: t = a != b;
          3'd4: t = $signed(a) < $signed(b);
          3'd5: t = $signed(a) >= $signed(b);
          3'd6: t = a < b;
          3'd7: t = a >= b;
          default: u = 1;
        endcase
        if (t) npc = ipc + ib;
      end
      default: u = 1;
    endcase
    if (u) npc = ipc;
    we = wr && !u && rd != 5'd0;
  endtask

  // Starts and ends at a falling edge with the block idle
  task automatic issue(input logic [31:0] in, ipc, a, b, input int hold,
                       input int exp_type, input int exp_in2lo);
    logic e_u, e_we, e_br;
    logic [4:0] e_rd;
    logic [31:0] e_data, e_npc;
    int lat;
    ref_model(in, ipc, a, b, e_u, e_we, e_br, e_rd, e_data, e_npc);
    chk("ready_idle", {31'b0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr = in; pc = ipc; rs1_data = a; rs2_data = b;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    chk("ready_exec", {31'b0, instr_ready}, 32'd0);
    chk("rvalid_exec", {31'b0, res_valid}, 32'd0);
    if (exp_type >= 0) chk("alu_type", {28'b0, alu_inst_type}, exp_type);
    if (exp_in2lo >= 0) chk("alu_in2_lo", {27'b0, alu_in2[4:0]}, exp_in2lo);
    lat = 0;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (e_br && !e_u) ? 32'd2 : 32'd1);
    o_we = rd_we; o_uns = unsup; o_rd = rd_addr; o_data = rd_data; o_npc = next_pc; o_lat = lat;
    chk("unsup", {31'b0, unsup}, {31'b0, e_u});
    chk("rd_we", {31'b0, rd_we}, {31'b0, e_we});
    chk("next_pc", next_pc, e_npc);
    if (!e_u && !e_br) begin
      chk("rd_addr", {27'b0, rd_addr}, {27'b0, e_rd});
      chk("rd_data", rd_data, e_data);
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      chk("hold_ready", {31'b0, instr_ready}, 32'd0);
      chk("hold_data", rd_data, o_data);
      chk("hold_npc", next_pc, o_npc);
      chk("hold_flags", {25'b0, o_uns, o_we, o_rd}, {25'b0, unsup, rd_we, rd_addr});
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("rvalid_drop", {31'b0, res_valid}, 32'd0);
    chk("ready_back", {31'b0, instr_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] w, r;
    logic [6:0]  ops [0:7];
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_flags", {29'b0, res_valid, rd_we, unsup}, 32'd0);
    chk("rst_rd", {27'b0, rd_addr} | rd_data | next_pc, 32'd0);
    chk("rst_alu", alu_in1 | alu_in2 | {28'b0, alu_inst_type}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h40, 32'd5, 32'd7, 0, 0, -1);
    chk("add_data", o_data, 32'd12);
    chk("add_rd", {27'b0, o_rd}, 32'd3);
    chk("add_we", {31'b0, o_we}, 32'd1);
    chk("add_npc", o_npc, 32'h44);
    chk("add_lat", o_lat, 32'd1);

    issue(enc_i(12'h404, 5'd6, 3'd5, 5'd5, 7'h13), 32'h80, 32'h8000_0000, 32'd0, 0, 7, 4);
    chk("srai_data", o_data, 32'hF800_0000);

    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 32'h84, 32'd0, 32'd1, 0, 1, -1);
    chk("sub_data", o_data, 32'hFFFF_FFFF);

    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h100, 32'd9, 32'd9, 0, 10, -1);
    chk("beq_npc", o_npc, 32'hF8);
    chk("beq_we", {31'b0, o_we}, 32'd0);
    chk("beq_lat", o_lat, 32'd2);

    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1), 32'h100, 32'd9, 32'd9, 0, 11, -1);
    chk("bne_npc", o_npc, 32'h104);

    issue(enc_i(12'd2, 5'd4, 3'd0, 5'd1, 7'h67), 32'h200, 32'h1001, 32'd0, 0, 0, -1);
    chk("jalr_npc", o_npc, 32'h1002);
    chk("jalr_data", o_data, 32'h204);
    chk("jalr_we", {31'b0, o_we}, 32'd1);
    issue(enc_i(12'd2, 5'd4, 3'd0, 5'd0, 7'h67), 32'h200, 32'h1001, 32'd0, 0, 0, -1);
    chk("jalr_x0_we", {31'b0, o_we}, 32'd0);

    // Stalled consumer, then back-to-back issue on the cycle after release
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd9, 7'h33), 32'h300, 32'hF0F0, 32'hFF00, 5, 9, -1);
    chk("hold_and", o_data, 32'hF000);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9, 7'h33), 32'h304, 32'hF0F0, 32'h0F0F, 0, 8, -1);
    chk("b2b_or", o_data, 32'hFFFF);

    issue(enc_i(12'd0, 5'd1, 3'd2, 5'd4, 7'h03), 32'h500, 32'd1, 32'd2, 0, -1, -1);
    chk("load_unsup", {31'b0, o_uns}, 32'd1);
    chk("load_we", {31'b0, o_we}, 32'd0);
    chk("load_npc", o_npc, 32'h500);

    // Reset while the branch target is being computed
    instr_valid = 1'b1; instr = enc_b(13'h0010, 5'd2, 5'd1, 3'd0); pc = 32'h600;
    rs1_data = 32'd3; rs2_data = 32'd3;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("brtgt_in1", alu_in1, 32'h600);
    chk("brtgt_in2", alu_in2, 32'h10);
    rst = 1'b1;
    chk("rst_mid_ready", {31'b0, instr_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_flags", {29'b0, res_valid, rd_we, unsup}, 32'd0);
    chk("rst_mid_rd", {27'b0, rd_addr} | rd_data | next_pc, 32'd0);
    chk("rst_mid_alu", alu_in1 | alu_in2 | {28'b0, alu_inst_type}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_result", {31'b0, res_valid}, 32'd0);
      chk("rst_ready_after", {31'b0, instr_ready}, 32'd1);
    end

    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 7)];
      r = $urandom;
      if (w[6:0] == 7'h67) w[14:12] = 3'd0;
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13)
        w[31:25] = (r[3:0] < 4'd7) ? 7'h00 : (r[3:0] < 4'd13) ? 7'h20 : r[10:4];
      if (w[6:0] == 7'h63 && r[12]) r[31:16] = r[15:0];  // force equal operands sometimes
      issue(w, $urandom & 32'hFFFF_FFFC, r[12] ? {r[15:0], r[15:0]} : $urandom,
            r[12] ? {r[15:0], r[15:0]} : $urandom, $urandom_range(0, 2), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
